// File: rtl/ex_mem_pkg.sv
// Shared widths, control constants and the EX/MEM register bundle type.
package ex_mem_pkg;

    localparam int RegBus       = 32;
    localparam int RegAddBus    = 5;
    localparam int AluOpBus     = 8;
    localparam int DoubleRegBus = 64;

    localparam logic RstEnable   = 1'b1;
    localparam logic WriteEnable = 1'b1;

    // Everything the EX/MEM register holds, including the madd/msub intermediate
    typedef struct packed {
        logic [RegAddBus-1:0]    wd;
        logic                    wreg;
        logic [RegBus-1:0]       wdata;
        logic                    whilo;
        logic [RegBus-1:0]       hi;
        logic [RegBus-1:0]       lo;
        logic [AluOpBus-1:0]     aluop;
        logic [RegBus-1:0]       mem_addr;
        logic [RegBus-1:0]       reg2;
        logic [DoubleRegBus-1:0] hilo;
        logic [1:0]              cnt;
    } ex_mem_regs_t;

    // What the register does on the next edge (reset is handled in the flop itself)
    typedef enum logic [1:0] {
        UPD_CLEAR  = 2'd0,
        UPD_BUBBLE = 2'd1,
        UPD_PASS   = 2'd2,
        UPD_HOLD   = 2'd3
    } upd_e;

    // Priority decode of flush and the execute/memory stall bits
    function automatic upd_e decode_update(input logic flush_i,
                                           input logic ex_stall_i,
                                           input logic mem_stall_i);
        upd_e upd;
        if (flush_i == 1'b1) begin
            upd = UPD_CLEAR;
        end else if (ex_stall_i == 1'b1 && mem_stall_i == 1'b0) begin
            upd = UPD_BUBBLE;
        end else if (ex_stall_i == 1'b0) begin
            upd = UPD_PASS;
        end else begin
            upd = UPD_HOLD;
        end
        return upd;
    endfunction

endpackage

// File: rtl/ex_mem.sv
// EX/MEM pipeline register: captures execute results, inserts bubbles on an
// execute-only stall, and parks the madd/msub intermediate while execute waits.
module ex_mem
    import ex_mem_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5:0]              stall,
    input  logic                    flush,
    input  logic [RegAddBus-1:0]    ex_wd,
    input  logic                    ex_wreg,
    input  logic [RegBus-1:0]       ex_wdata,
    input  logic                    ex_whilo,
    input  logic [RegBus-1:0]       ex_hi,
    input  logic [RegBus-1:0]       ex_lo,
    input  logic [AluOpBus-1:0]     ex_aluop,
    input  logic [RegBus-1:0]       ex_mem_addr,
    input  logic [RegBus-1:0]       ex_reg2,
    input  logic [DoubleRegBus-1:0] hilo_i,
    input  logic [1:0]              cnt_i,
    output logic [RegAddBus-1:0]    mem_wd,
    output logic                    mem_wreg,
    output logic [RegBus-1:0]       mem_wdata,
    output logic                    mem_whilo,
    output logic [RegBus-1:0]       mem_hi,
    output logic [RegBus-1:0]       mem_lo,
    output logic [AluOpBus-1:0]     mem_aluop,
    output logic [RegBus-1:0]       mem_mem_addr,
    output logic [RegBus-1:0]       mem_reg2,
    output logic [DoubleRegBus-1:0] hilo_o,
    output logic [1:0]              cnt_o
);

    ex_mem_regs_t ex_s;
    ex_mem_regs_t regs_d;
    ex_mem_regs_t regs_q;
    upd_e         upd_s;
    logic         unused_stall_s;

    // Only the execute and memory stall bits matter to this stage
    assign unused_stall_s = ^{stall[5], stall[2:0]};

    // Gather the execute-side inputs into one bundle
    always_comb begin
        ex_s          = '0;
        ex_s.wd       = ex_wd;
        ex_s.wreg     = ex_wreg;
        ex_s.wdata    = ex_wdata;
        ex_s.whilo    = ex_whilo;
        ex_s.hi       = ex_hi;
        ex_s.lo       = ex_lo;
        ex_s.aluop    = ex_aluop;
        ex_s.mem_addr = ex_mem_addr;
        ex_s.reg2     = ex_reg2;
        ex_s.hilo     = hilo_i;
        ex_s.cnt      = cnt_i;
    end

    // Next-state priority chain: flush, bubble, pass-through, hold
    always_comb begin
        regs_d = regs_q;
        upd_s  = decode_update(flush, stall[3], stall[4]);
        case (upd_s)
            UPD_CLEAR: begin
                regs_d = '0;
            end
            UPD_BUBBLE: begin
                // Bubble writes nothing downstream but keeps execute's intermediate
                regs_d      = '0;
                regs_d.hilo = ex_s.hilo;
                regs_d.cnt  = ex_s.cnt;
            end
            UPD_PASS: begin
                // Intermediate is only meaningful across a stall; drop it on advance
                regs_d      = ex_s;
                regs_d.hilo = '0;
                regs_d.cnt  = 2'd0;
            end
            UPD_HOLD: begin
                regs_d = regs_q;
            end
            default: begin
                regs_d = '0;
            end
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign mem_wd       = regs_q.wd;
    assign mem_wreg     = regs_q.wreg;
    assign mem_wdata    = regs_q.wdata;
    assign mem_whilo    = regs_q.whilo;
    assign mem_hi       = regs_q.hi;
    assign mem_lo       = regs_q.lo;
    assign mem_aluop    = regs_q.aluop;
    assign mem_mem_addr = regs_q.mem_addr;
    assign mem_reg2     = regs_q.reg2;
    assign hilo_o       = regs_q.hilo;
    assign cnt_o        = regs_q.cnt;

endmodule
